// File: rtl/barrett_modmul_ctrl_64b_pkg.sv
// Shared types and constants for the Barrett modular-multiply sequencer.
package barrett_modmul_ctrl_64b_pkg;

  localparam int DW      = 64;
  localparam int PW      = 128;
  localparam int MUL_LAT = 3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MUL_X  = 3'd1,
    S_MUL_Q  = 3'd2,
    S_MUL_QM = 3'd3,
    S_CORR1  = 3'd4,
    S_CORR2  = 3'd5,
    S_DONE   = 3'd6
  } state_e;

  function automatic bit barrett_k_ok(input int k);
    return (k >= 8) && (k <= 63);
  endfunction

endpackage

// File: rtl/barrett_cond_sub.sv
// Barrett final correction step: one conditional subtraction of the modulus.
module barrett_cond_sub #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_r,
  input  logic [W-1:0] i_m,
  output logic [W-1:0] o_r
);

  assign o_r = (i_r >= i_m) ? (i_r - i_m) : i_r;

endmodule

// File: rtl/barrett_modmul_ctrl_64b.sv
// (A*B) mod M sequencer: drives one shared pipelined multiplier through the
// three Barrett products, then applies two fixed correction cycles.
module barrett_modmul_ctrl_64b
  import barrett_modmul_ctrl_64b_pkg::*;
#(
  parameter int K       = 63,
  parameter int MUL_LAT = barrett_modmul_ctrl_64b_pkg::MUL_LAT
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iClr,
  input  logic          iValid,
  output logic          oReady,
  input  logic [63:0]   iDataA,
  input  logic [63:0]   iDataB,
  input  logic [63:0]   iMod,
  input  logic [63:0]   iMu,
  output logic          oValid,
  input  logic          iReady,
  output logic [63:0]   oData,
  output logic          oBusy,
  output logic          oMulEn,
  output logic          oMulClr,
  output logic [63:0]   oMulData0,
  output logic [63:0]   oMulData1,
  input  logic [127:0]  iMulData
);

  localparam int RW = K + 1;
  localparam int XW = 2 * K;
  localparam int CW = $clog2(MUL_LAT + 1);

  if (!barrett_k_ok(K) || (MUL_LAT < 1)) begin : g_param_err
    $error("barrett_modmul_ctrl_64b: unsupported K or MUL_LAT");
  end

  state_e          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic [DW-1:0]   r_a, r_b, r_m, r_mu;
  logic [XW-1:0]   r_x;
  logic [RW-1:0]   r_q3, r_r, w_sub;
  logic            w_flush, w_mul, w_cnt_last;
  logic            w_unused;

  assign w_flush    = !iRstN || iClr;
  assign w_mul      = (r_state == S_MUL_X) || (r_state == S_MUL_Q) || (r_state == S_MUL_QM);
  assign w_cnt_last = (r_cnt == CW'(MUL_LAT));
  assign oMulClr    = w_flush;
  // Product bits above 2K+1 are irrelevant for small K.
  assign w_unused   = ^iMulData;

  barrett_cond_sub #(.W(RW)) u_cond_sub (
    .i_r (r_r),
    .i_m (r_m[RW-1:0]),
    .o_r (w_sub)
  );

  always_ff @(posedge iClk) begin
    if (!iRstN) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (iValid)     w_next = S_MUL_X;
      S_MUL_X:  if (w_cnt_last) w_next = S_MUL_Q;
      S_MUL_Q:  if (w_cnt_last) w_next = S_MUL_QM;
      S_MUL_QM: if (w_cnt_last) w_next = S_CORR1;
      S_CORR1:                  w_next = S_CORR2;
      S_CORR2:                  w_next = S_DONE;
      S_DONE:   if (iReady)     w_next = S_IDLE;
      default:                  w_next = S_IDLE;
    endcase
    if (iClr) w_next = S_IDLE;
  end

  // Products are taken on the last count of each multiply, once the
  // operands sampled on the first count have left the pipeline.
  always_ff @(posedge iClk) begin
    if (w_flush) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_m   <= '0;
      r_mu  <= '0;
      r_x   <= '0;
      r_q3  <= '0;
      r_r   <= '0;
    end else begin
      r_cnt <= (w_mul && !w_cnt_last) ? r_cnt + CW'(1) : '0;
      case (r_state)
        S_IDLE: if (iValid) begin
          r_a  <= iDataA;
          r_b  <= iDataB;
          r_m  <= iMod;
          r_mu <= iMu;
        end
        S_MUL_X:  if (w_cnt_last) r_x  <= iMulData[XW-1:0];
        S_MUL_Q:  if (w_cnt_last) r_q3 <= iMulData[2*K+1:K+1];
        S_MUL_QM: if (w_cnt_last) r_r  <= r_x[RW-1:0] - iMulData[RW-1:0];
        S_CORR1, S_CORR2:         r_r  <= w_sub;
        default: ;
      endcase
    end
  end

  always_comb begin
    oReady    = 1'b0;
    oBusy     = 1'b1;
    oValid    = 1'b0;
    oData     = '0;
    oMulEn    = 1'b0;
    oMulData0 = '0;
    oMulData1 = '0;
    case (r_state)
      S_IDLE: begin
        oReady = 1'b1;
        oBusy  = 1'b0;
      end
      S_MUL_X: begin
        oMulEn    = 1'b1;
        oMulData0 = r_a;
        oMulData1 = r_b;
      end
      S_MUL_Q: begin
        oMulEn    = 1'b1;
        oMulData0 = DW'(r_x[XW-1:K-1]);
        oMulData1 = r_mu;
      end
      S_MUL_QM: begin
        oMulEn    = 1'b1;
        oMulData0 = DW'(r_q3);
        oMulData1 = r_m;
      end
      S_DONE: begin
        oValid = 1'b1;
        oData  = DW'(r_r);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_barrett_modmul_ctrl_64b.sv
// Directed bench: a K=8 and a K=63 instance share stimulus and run in lockstep.
module tb_barrett_modmul_ctrl_64b;

  localparam logic [63:0] M63  = 64'h7FFF_FFFF_FFFF_FFE7;
  localparam logic [63:0] MU63 = 64'h8000_0000_0000_0019;

  typedef struct {
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] m;
    logic [63:0] mu;
    logic [63:0] exp;
    string       name;
  } vec_t;

  logic         iClk = 1'b0;
  logic         iRstN, iClr, iValid, iReady;
  logic [63:0]  iDataA, iDataB, iMod, iMu;

  logic         rdy  [2];
  logic         vld  [2];
  logic         busy [2];
  logic         en   [2];
  logic         clr  [2];
  logic [63:0]  dat  [2];
  logic [63:0]  mo0  [2];
  logic [63:0]  mo1  [2];
  logic [127:0] prod [2];

  int n_chk  = 0;
  int n_fail = 0;
  vec_t vecs [9];

  always #5 iClk = ~iClk;

  barrett_modmul_ctrl_64b #(.K(8)) u_dut8 (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iValid(iValid), .oReady(rdy[0]),
    .iDataA(iDataA), .iDataB(iDataB), .iMod(iMod), .iMu(iMu),
    .oValid(vld[0]), .iReady(iReady), .oData(dat[0]), .oBusy(busy[0]),
    .oMulEn(en[0]), .oMulClr(clr[0]), .oMulData0(mo0[0]), .oMulData1(mo1[0]),
    .iMulData(prod[0])
  );

  barrett_modmul_ctrl_64b #(.K(63)) u_dut63 (
    .iClk(iClk), .iRstN(iRstN), .iClr(iClr), .iValid(iValid), .oReady(rdy[1]),
    .iDataA(iDataA), .iDataB(iDataB), .iMod(iMod), .iMu(iMu),
    .oValid(vld[1]), .iReady(iReady), .oData(dat[1]), .oBusy(busy[1]),
    .oMulEn(en[1]), .oMulClr(clr[1]), .oMulData0(mo0[1]), .oMulData1(mo1[1]),
    .iMulData(prod[1])
  );

  // 3-stage enabled multiplier, flushed by its clear input.
  for (genvar g = 0; g < 2; g++) begin : g_mul
    logic [127:0] s1, s2, s3;
    always @(posedge iClk) begin
      if (clr[g]) begin
        s1 <= '0;
        s2 <= '0;
        s3 <= '0;
      end else if (en[g]) begin
        s1 <= {64'd0, mo0[g]} * {64'd0, mo1[g]};
        s2 <= s1;
        s3 <= s2;
      end
    end
    assign prod[g] = s3;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    end
  endtask

  task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic start_req(input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] m, input logic [63:0] mu);
    iDataA = a;
    iDataB = b;
    iMod   = m;
    iMu    = mu;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
  endtask

  // Starts right after the accepting edge; bounded so a stuck DUT still ends.
  task automatic wait_valid(input int s, output int lat, output int ens);
    lat = 0;
    ens = 0;
    while (!vld[s] && lat < 40) begin
      if (en[s]) ens++;
      tick();
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat, ens;
    chk1({v.name, "_ready_before"}, rdy[v.sel], 1'b1);
    start_req(v.a, v.b, v.m, v.mu);
    chk1({v.name, "_busy"}, busy[v.sel], 1'b1);
    chk1({v.name, "_ready_busy"}, rdy[v.sel], 1'b0);
    wait_valid(v.sel, lat, ens);
    chk64({v.name, "_latency"}, 64'(lat), 64'd14);
    chk64({v.name, "_mulen_cycles"}, 64'(ens), 64'd12);
    chk64({v.name, "_data"}, dat[v.sel], v.exp);
    tick();
    chk1({v.name, "_ready_after"}, rdy[v.sel], 1'b1);
    chk1({v.name, "_valid_after"}, vld[v.sel], 1'b0);
  endtask

  initial begin
    int lat, ens, seen;
    iRstN  = 1'b0;
    iClr   = 1'b0;
    iValid = 1'b0;
    iReady = 1'b1;
    iDataA = '0;
    iDataB = '0;
    iMod   = '0;
    iMu    = '0;

    vecs[0] = '{0, 64'd200, 64'd150, 64'd251, 64'd261, 64'd131, "k8_basic"};
    vecs[1] = '{0, 64'd250, 64'd250, 64'd251, 64'd261, 64'd1,   "k8_max"};
    vecs[2] = '{0, 64'd0,   64'd77,  64'd251, 64'd261, 64'd0,   "k8_zero"};
    vecs[3] = '{0, 64'd128, 64'd128, 64'd129, 64'd508, 64'd1,   "k8_m129"};
    vecs[4] = '{0, 64'd239, 64'd237, 64'd241, 64'd271, 64'd8,   "k8_two_corr"};
    vecs[5] = '{1, M63 - 64'd1, M63 - 64'd1, M63, MU63, 64'd1,  "k63_max"};
    vecs[6] = '{1, 64'd0, M63 - 64'd1, M63, MU63, 64'd0,        "k63_zero"};
    vecs[7] = '{1, 64'h4000_0000_0000_0000, 64'd4, M63, MU63, 64'd50, "k63_pow2"};
    vecs[8] = '{1, 64'd3, 64'd5, M63, MU63, 64'd15,             "k63_small"};

    tick();
    tick();
    chk1("rst_mulclr", clr[1], 1'b1);
    chk1("rst_ready", rdy[0], 1'b1);
    chk1("rst_valid", vld[1], 1'b0);
    chk1("rst_busy", busy[0], 1'b0);
    chk1("rst_mulen", en[1], 1'b0);
    chk64("rst_data", dat[1], 64'd0);
    iRstN = 1'b1;
    tick();
    chk1("post_rst_mulclr", clr[0], 1'b0);
    chk1("post_rst_ready", rdy[1], 1'b1);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure: result must hold while the consumer stalls.
    iReady = 1'b0;
    start_req(64'd200, 64'd150, 64'd251, 64'd261);
    wait_valid(0, lat, ens);
    chk64("bp_latency", 64'(lat), 64'd14);
    for (int i = 0; i < 5; i++) begin
      chk1("bp_valid_hold", vld[0], 1'b1);
      chk64("bp_data_hold", dat[0], 64'd131);
      chk1("bp_ready_low", rdy[0], 1'b0);
      tick();
    end
    iReady = 1'b1;
    tick();
    chk1("bp_release_ready", rdy[0], 1'b1);
    chk1("bp_release_valid", vld[0], 1'b0);
    run_vec(vecs[4]);

    // Clear during MUL_Q, count 1.
    start_req(vecs[5].a, vecs[5].b, vecs[5].m, vecs[5].mu);
    for (int i = 0; i < 5; i++) tick();
    chk1("clr_in_mulq_en", en[1], 1'b1);
    chk64("clr_in_mulq_mu_operand", mo1[1], MU63);
    iClr = 1'b1;
    #1;
    chk1("clr_mulclr_same_cycle", clr[1], 1'b1);
    tick();
    iClr = 1'b0;
    #1;
    chk1("clr_mulclr_pulse_end", clr[1], 1'b0);
    chk1("clr_busy", busy[1], 1'b0);
    chk1("clr_ready", rdy[1], 1'b1);
    chk1("clr_mulen", en[1], 1'b0);
    chk64("clr_operand0", mo0[1], 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (vld[1] || vld[0]) seen++;
      tick();
    end
    chk64("clr_no_valid", 64'(seen), 64'd0);
    run_vec(vecs[5]);

    // Reset pulse during MUL_QM with a request offered during reset.
    start_req(vecs[7].a, vecs[7].b, vecs[7].m, vecs[7].mu);
    for (int i = 0; i < 9; i++) tick();
    chk64("rst_mid_m_operand", mo1[1], M63);
    iRstN  = 1'b0;
    iValid = 1'b1;
    #1;
    chk1("rst_mid_mulclr", clr[1], 1'b1);
    tick();
    iRstN  = 1'b1;
    iValid = 1'b0;
    chk1("rst_mid_valid", vld[1], 1'b0);
    chk64("rst_mid_data", dat[1], 64'd0);
    chk1("rst_mid_busy", busy[1], 1'b0);
    chk1("rst_mid_mulen", en[1], 1'b0);
    chk64("rst_mid_op0", mo0[1], 64'd0);
    chk64("rst_mid_op1", mo1[1], 64'd0);
    chk1("rst_mid_ready", rdy[1], 1'b1);
    tick();
    chk1("rst_mid_valid_ignored", busy[1], 1'b0);
    run_vec(vecs[7]);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
